// File: rtl/wr_recovery_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wr_recovery_ctrl_pkg
// Description : Shared types for the write-path recovery controller.
// Revision    : 1.0 - initial release
// ============================================================================
package wr_recovery_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISOLATE = 3'd1,
        RESET   = 3'd2,
        FLUSH   = 3'd3,
        RELEASE = 3'd4
    } recovery_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'd0,
        CAUSE_TIMEOUT   = 2'd1,
        CAUSE_RESET_REQ = 2'd2,
        CAUSE_SW        = 2'd3
    } recovery_cause_e;

    // Fixed priority: timeout over reset request over software request.
    function automatic recovery_cause_e f_cause(
        input logic timeout,
        input logic reset_req,
        input logic sw
    );
        if (timeout) begin
            return CAUSE_TIMEOUT;
        end
        if (reset_req) begin
            return CAUSE_RESET_REQ;
        end
        if (sw) begin
            return CAUSE_SW;
        end
        return CAUSE_NONE;
    endfunction

endpackage : wr_recovery_ctrl_pkg
`default_nettype wire

// File: rtl/wr_recovery_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : wr_recovery_ctrl_if
// Description : Trigger, W-channel observation and gating/status bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface wr_recovery_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 timeout_i;
    logic                 reset_req_i;
    logic                 sw_reset_i;
    logic                 clr_i;
    logic                 w_valid_i;
    logic                 w_ready_i;
    logic                 w_last_i;
    logic                 block_aw_o;
    logic                 block_w_o;
    logic                 slv_rst_no;
    logic                 txn_clear_o;
    logic                 busy_o;
    logic                 done_o;
    logic [1:0]           cause_o;
    logic                 overrun_o;
    logic [CNT_WIDTH-1:0] recovery_cnt_o;

    modport master (
        output timeout_i, reset_req_i, sw_reset_i, clr_i,
        output w_valid_i, w_ready_i, w_last_i,
        input  block_aw_o, block_w_o, slv_rst_no, txn_clear_o,
        input  busy_o, done_o, cause_o, overrun_o, recovery_cnt_o
    );

    modport slave (
        input  timeout_i, reset_req_i, sw_reset_i, clr_i,
        input  w_valid_i, w_ready_i, w_last_i,
        output block_aw_o, block_w_o, slv_rst_no, txn_clear_o,
        output busy_o, done_o, cause_o, overrun_o, recovery_cnt_o
    );

endinterface : wr_recovery_ctrl_if
`default_nettype wire

// File: rtl/wr_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wr_recovery_ctrl
// Description : Isolates, resets and flushes the write path after a fault.
//               WR_RECOVERY_DRAIN_EN lets an open W burst close in ISOLATE.
// Revision    : 1.0 - initial release
// ============================================================================
module wr_recovery_ctrl
    import wr_recovery_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned DRAIN_CYCLES = 64,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    wr_recovery_ctrl_if.slave  bus
);

    localparam int unsigned c_TMR_MAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
    localparam int unsigned c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_TMR_W-1:0]   c_RESET_LOAD = c_TMR_W'(RESET_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]   c_TMR_ONE    = c_TMR_W'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX    = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE    = CNT_WIDTH'(1);

    recovery_state_e        r_state;
    logic [c_TMR_W-1:0]     r_tmr;
    logic                   r_block_aw;
    logic                   r_block_w;
    logic                   r_slv_rst_n;
    logic                   r_txn_clear;
    logic                   r_busy;
    logic                   r_done;
    recovery_cause_e        r_cause;
    logic                   r_overrun;
    logic [CNT_WIDTH-1:0]   r_recovery_cnt;

    logic                   w_trigger;
    recovery_cause_e        w_cause;
    logic                   w_isolate_done;
    logic                   w_isolate_block_w;

    assign w_trigger = bus.timeout_i | bus.reset_req_i | bus.sw_reset_i;
    assign w_cause   = f_cause(bus.timeout_i, bus.reset_req_i, bus.sw_reset_i);

`ifdef WR_RECOVERY_DRAIN_EN
    localparam logic [c_TMR_W-1:0] c_DRAIN_LOAD = c_TMR_W'(DRAIN_CYCLES - 1);

    logic r_burst_open;

    // Tracks the W channel in every state so ISOLATE knows whether a burst is in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_burst_open <= 1'b0;
        end else if (bus.w_valid_i && bus.w_ready_i) begin
            r_burst_open <= !bus.w_last_i;
        end
    end

    assign w_isolate_done    = !r_burst_open || (r_tmr == '0);
    assign w_isolate_block_w = 1'b0;
`else
    localparam logic [c_TMR_W-1:0] c_DRAIN_LOAD = '0;

    logic w_unused_w_chan;
    assign w_unused_w_chan   = &{1'b0, bus.w_valid_i, bus.w_ready_i, bus.w_last_i};
    assign w_isolate_done    = 1'b1;
    assign w_isolate_block_w = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state        <= IDLE;
            r_tmr          <= '0;
            r_block_aw     <= 1'b0;
            r_block_w      <= 1'b0;
            r_slv_rst_n    <= 1'b1;
            r_txn_clear    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_cause        <= CAUSE_NONE;
            r_overrun      <= 1'b0;
            r_recovery_cnt <= '0;
        end else begin
            r_txn_clear <= 1'b0;
            r_done      <= 1'b0;

            // A trigger while busy beats a simultaneous clear.
            if (bus.clr_i) begin
                r_overrun <= 1'b0;
            end
            if (w_trigger && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end

            unique case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_state    <= ISOLATE;
                        r_cause    <= w_cause;
                        r_busy     <= 1'b1;
                        r_block_aw <= 1'b1;
                        r_block_w  <= w_isolate_block_w;
                        r_tmr      <= c_DRAIN_LOAD;
                    end else if (bus.clr_i) begin
                        r_cause <= CAUSE_NONE;
                    end
                end
                ISOLATE: begin
                    if (w_isolate_done) begin
                        r_state     <= RESET;
                        r_block_w   <= 1'b1;
                        r_slv_rst_n <= 1'b0;
                        r_tmr       <= c_RESET_LOAD;
                    end else begin
                        r_tmr <= r_tmr - c_TMR_ONE;
                    end
                end
                RESET: begin
                    if (r_tmr == '0) begin
                        r_state     <= FLUSH;
                        r_slv_rst_n <= 1'b1;
                        r_txn_clear <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr - c_TMR_ONE;
                    end
                end
                FLUSH: begin
                    r_state <= RELEASE;
                    r_done  <= 1'b1;
                    if (r_recovery_cnt != c_CNT_MAX) begin
                        r_recovery_cnt <= r_recovery_cnt + c_CNT_ONE;
                    end
                end
                RELEASE: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_block_aw <= 1'b0;
                    r_block_w  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.block_aw_o     = r_block_aw;
    assign bus.block_w_o      = r_block_w;
    assign bus.slv_rst_no     = r_slv_rst_n;
    assign bus.txn_clear_o    = r_txn_clear;
    assign bus.busy_o         = r_busy;
    assign bus.done_o         = r_done;
    assign bus.cause_o        = r_cause;
    assign bus.overrun_o      = r_overrun;
    assign bus.recovery_cnt_o = r_recovery_cnt;

endmodule : wr_recovery_ctrl
`default_nettype wire

// File: tb/tb_wr_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wr_recovery_ctrl
// Description : Self-checking bench for wr_recovery_ctrl with a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wr_recovery_ctrl;

    localparam int unsigned RESET_CYCLES = 4;
    localparam int unsigned DRAIN_CYCLES = 10;
    localparam int unsigned CNT_WIDTH    = 2;
    localparam int          c_VW         = 9 + CNT_WIDTH;
    localparam int          c_CNT_SAT    = (1 << CNT_WIDTH) - 1;
    localparam logic [c_VW-1:0] c_RESET_VEC = {6'b000100, 3'b000, {CNT_WIDTH{1'b0}}};
`ifdef WR_RECOVERY_DRAIN_EN
    localparam bit c_DRAIN = 1'b1;
`else
    localparam bit c_DRAIN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    always #5 clk = ~clk;

    wr_recovery_ctrl_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

    wr_recovery_ctrl #(
        .RESET_CYCLES (RESET_CYCLES),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .CNT_WIDTH    (CNT_WIDTH)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    logic [c_VW-1:0] dut_vec;
    assign dut_vec = {bus.busy_o, bus.block_aw_o, bus.block_w_o, bus.slv_rst_no,
                      bus.txn_clear_o, bus.done_o, bus.cause_o, bus.overrun_o,
                      bus.recovery_cnt_o};

    // Reference model: a recovery started by a trigger in cycle m_s occupies cycles
    // m_s+1 .. m_s+len+R+2 as isolate(len), reset(R), flush(1), release(1).
    int         m_k;
    int         m_s;
    int         m_len;
    int         m_next_iso;
    int         m_cnt;
    bit         m_active;
    bit         m_overrun;
    logic [1:0] m_cause;

    function automatic int m_off();
        return m_k - m_s;
    endfunction

    function automatic bit m_in_seq();
        return m_active && (m_off() >= 1) && (m_off() <= m_len + int'(RESET_CYCLES) + 2);
    endfunction

    function automatic logic [c_VW-1:0] model_vec();
        bit seq;
        int o;
        int rs;
        seq = m_in_seq();
        o   = m_off();
        rs  = m_len + int'(RESET_CYCLES);
        return {seq, seq, seq && !(c_DRAIN && o <= m_len), !(seq && o > m_len && o <= rs),
                seq && (o == rs + 1), seq && (o == rs + 2), m_cause, m_overrun,
                CNT_WIDTH'(m_cnt)};
    endfunction

    task automatic model_edge();
        bit trig;
        trig = bus.timeout_i | bus.reset_req_i | bus.sw_reset_i;
        if (!rst_n) begin
            m_active  = 1'b0;
            m_cause   = 2'd0;
            m_overrun = 1'b0;
            m_cnt     = 0;
        end else if (m_in_seq()) begin
            if (trig) m_overrun = 1'b1;
            else if (bus.clr_i) m_overrun = 1'b0;
            if (m_off() == m_len + int'(RESET_CYCLES) + 1 && m_cnt < c_CNT_SAT) m_cnt++;
        end else begin
            if (bus.clr_i) m_overrun = 1'b0;
            if (trig) begin
                m_cause  = bus.timeout_i ? 2'd1 : (bus.reset_req_i ? 2'd2 : 2'd3);
                m_active = 1'b1;
                m_s      = m_k;
                m_len    = m_next_iso;
            end else if (bus.clr_i) begin
                m_cause = 2'd0;
            end
        end
        m_k++;
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_idle();
        bus.timeout_i   = 1'b0;
        bus.reset_req_i = 1'b0;
        bus.sw_reset_i  = 1'b0;
        bus.clr_i       = 1'b0;
        bus.w_valid_i   = 1'b0;
        bus.w_ready_i   = 1'b0;
        bus.w_last_i    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clk_step();
        clk_step();
        n_tests++;
        if (dut_vec !== c_RESET_VEC) begin
            n_fail++; $display("FAIL reset_vec: got %b expected %b", dut_vec, c_RESET_VEC);
        end
        n_tests++;
        if (bus.slv_rst_no !== 1'b1) begin
            n_fail++; $display("FAIL reset_slv_rst_n: got %b expected 1", bus.slv_rst_no);
        end
        n_tests++;
        if (bus.busy_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o);
        end
        rst_n = 1'b1;
        clk_step();
        n_tests++;
        if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL reset_release: got %b expected %b", dut_vec, model_vec());
        end
    endtask

    task automatic test_timeout();
        int rst_low;
        int txn_n;
        int done_at;
        rst_low = 0;
        txn_n   = 0;
        done_at = -1;
        bus.timeout_i = 1'b1;
        clk_step();
        bus.timeout_i = 1'b0;
        n_tests++;
        if (bus.busy_o !== 1'b1 || bus.cause_o !== 2'd1) begin
            n_fail++; $display("FAIL timeout_start: busy %b cause %0d expected busy 1 cause 1", bus.busy_o, bus.cause_o);
        end
        for (int i = 1; i <= 10; i++) begin
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL timeout_seq[%0d]: got %b expected %b", i, dut_vec, model_vec());
            end
            if (!bus.slv_rst_no) rst_low++;
            if (bus.txn_clear_o) txn_n++;
            if (bus.done_o && done_at < 0) done_at = i + 1;  // trigger cycle counts as cycle 1
            clk_step();
        end
        n_tests++;
        if (rst_low != int'(RESET_CYCLES)) begin
            n_fail++; $display("FAIL slv_rst_len: got %0d expected %0d", rst_low, RESET_CYCLES);
        end
        n_tests++;
        if (txn_n != 1) begin
            n_fail++; $display("FAIL txn_clear_pulses: got %0d expected 1", txn_n);
        end
        n_tests++;
        if (done_at != 1 + 1 + int'(RESET_CYCLES) + 1 + 1) begin
            n_fail++; $display("FAIL done_latency: got %0d expected %0d", done_at, RESET_CYCLES + 4);
        end
        n_tests++;
        if (bus.recovery_cnt_o !== CNT_WIDTH'(1)) begin
            n_fail++; $display("FAIL recovery_cnt: got %0d expected 1", bus.recovery_cnt_o);
        end
    endtask

    task automatic test_priority_overrun();
        int guard;
        bus.timeout_i  = 1'b1;
        bus.sw_reset_i = 1'b1;
        clk_step();
        drive_idle();
        n_tests++;
        if (bus.cause_o !== 2'd1) begin
            n_fail++; $display("FAIL cause_priority: got %0d expected 1", bus.cause_o);
        end
        clk_step();
        clk_step();
        bus.sw_reset_i = 1'b1;
        clk_step();
        bus.sw_reset_i = 1'b0;
        n_tests++;
        if (bus.overrun_o !== 1'b1 || bus.cause_o !== 2'd1) begin
            n_fail++; $display("FAIL overrun_set: overrun %b cause %0d expected overrun 1 cause 1", bus.overrun_o, bus.cause_o);
        end
        guard = 0;
        while (bus.busy_o === 1'b1 && guard < 40) begin
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL overrun_seq: got %b expected %b", dut_vec, model_vec());
            end
            clk_step();
            guard++;
        end
        n_tests++;
        if (guard >= 40) begin
            n_fail++; $display("FAIL overrun_idle_wait: busy still %b after %0d cycles", bus.busy_o, guard);
        end
        bus.clr_i = 1'b1;
        clk_step();
        bus.clr_i = 1'b0;
        n_tests++;
        if (bus.overrun_o !== 1'b0 || bus.cause_o !== 2'd0) begin
            n_fail++; $display("FAIL clr_idle: overrun %b cause %0d expected 0 0", bus.overrun_o, bus.cause_o);
        end
    endtask

    task automatic test_reset_mid();
        bus.reset_req_i = 1'b1;
        clk_step();
        bus.reset_req_i = 1'b0;
        clk_step();
        clk_step();
        n_tests++;
        if (bus.slv_rst_no !== 1'b0 || bus.cause_o !== 2'd2) begin
            n_fail++; $display("FAIL mid_in_reset: slv_rst_n %b cause %0d expected 0 2", bus.slv_rst_no, bus.cause_o);
        end
        rst_n = 1'b0;
        clk_step();
        n_tests++;
        if (dut_vec !== c_RESET_VEC) begin
            n_fail++; $display("FAIL mid_reset_vec: got %b expected %b", dut_vec, c_RESET_VEC);
        end
        rst_n = 1'b1;
        clk_step();
    endtask

    task automatic test_saturation();
        int guard;
        for (int i = 1; i <= 5; i++) begin
            bus.sw_reset_i = 1'b1;
            clk_step();
            bus.sw_reset_i = 1'b0;
            guard = 0;
            while (bus.busy_o === 1'b1 && guard < 40) begin
                n_tests++;
                if (dut_vec !== model_vec()) begin
                    n_fail++; $display("FAIL sat_seq[%0d]: got %b expected %b", i, dut_vec, model_vec());
                end
                clk_step();
                guard++;
            end
            n_tests++;
            if (guard >= 40 || bus.recovery_cnt_o !== CNT_WIDTH'((i < c_CNT_SAT) ? i : c_CNT_SAT)) begin
                n_fail++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d (wait %0d)", i, bus.recovery_cnt_o, (i < c_CNT_SAT) ? i : c_CNT_SAT, guard);
            end
        end
    endtask

    task automatic test_drain(input bit with_last);
        int exp_iso;
        int iso;
        bit seen_low;
        bit bw_bad;
        exp_iso = c_DRAIN ? (with_last ? 4 : int'(DRAIN_CYCLES)) : 1;
        iso = 0;
        seen_low = 1'b0;
        bw_bad = 1'b0;
        bus.w_valid_i = 1'b1;
        bus.w_ready_i = 1'b1;
        bus.w_last_i  = 1'b0;
        clk_step();
        drive_idle();
        m_next_iso    = exp_iso;
        bus.timeout_i = 1'b1;
        clk_step();
        bus.timeout_i = 1'b0;
        m_next_iso    = 1;
        for (int i = 1; i <= int'(DRAIN_CYCLES + RESET_CYCLES) + 6; i++) begin
            bus.w_valid_i = with_last && (i == 3);
            bus.w_ready_i = with_last && (i == 3);
            bus.w_last_i  = with_last && (i == 3);
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL drain_seq[%0d]: got %b expected %b", i, dut_vec, model_vec());
            end
            if (!bus.slv_rst_no) begin
                seen_low = 1'b1;
            end else if (bus.busy_o && !seen_low) begin
                iso++;
                if (bus.block_w_o !== !c_DRAIN) bw_bad = 1'b1;
            end
            clk_step();
        end
        drive_idle();
        n_tests++;
        if (iso != exp_iso) begin
            n_fail++; $display("FAIL isolate_len(last=%0d): got %0d expected %0d", with_last, iso, exp_iso);
        end
        n_tests++;
        if (bw_bad) begin
            n_fail++; $display("FAIL isolate_block_w(last=%0d): got wrong level expected %b", with_last, !c_DRAIN);
        end
        bus.w_valid_i = 1'b1;
        bus.w_ready_i = 1'b1;
        bus.w_last_i  = 1'b1;
        clk_step();
        drive_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            bus.timeout_i   = ($urandom_range(0, 24) == 0);
            bus.reset_req_i = ($urandom_range(0, 24) == 0);
            bus.sw_reset_i  = ($urandom_range(0, 24) == 0);
            bus.clr_i       = ($urandom_range(0, 9) == 0);
            rst_n           = ($urandom_range(0, 149) != 0);
            clk_step();
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL random[%0d]: got %b expected %b", i, dut_vec, model_vec());
            end
        end
        drive_idle();
        rst_n = 1'b1;
        clk_step();
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        m_k        = 0;
        m_s        = 0;
        m_len      = 1;
        m_next_iso = 1;
        m_cnt      = 0;
        m_active   = 1'b0;
        m_overrun  = 1'b0;
        m_cause    = 2'd0;
        rst_n      = 1'b0;
        drive_idle();
        test_reset();
        test_timeout();
        test_priority_overrun();
        test_reset_mid();
        test_saturation();
        test_drain(1'b1);
        test_drain(1'b0);
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wr_recovery_ctrl
`default_nettype wire
